// File: rtl/mtm_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mtm_alu_pkg
//  Description : Shared types, field positions and the CRC3 helper for the
//                MTM ALU response receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package mtm_alu_pkg;

    // Packet type bit carried right after the start bit
    typedef enum logic {
        PKT_DATA = 1'b0,
        PKT_CTL  = 1'b1
    } pkt_type_t;

    // Serial packet framing: start + type + 8 data + stop
    localparam int PKT_BITS   = 11;
    // Result C is carried in this many DATA packets, MSB byte first
    localparam int DATA_BYTES = 4;

    // Bit positions inside the rsp_flags word {carry, overflow, zero, negative}
    localparam int FLAG_CARRY    = 3;
    localparam int FLAG_OVERFLOW = 2;
    localparam int FLAG_ZERO     = 1;
    localparam int FLAG_NEGATIVE = 0;

    // Bit positions inside rsp_err_flags {DATA, CRC, OP, DATA, CRC, OP}
    localparam int ERRF_DATA_A = 5;
    localparam int ERRF_CRC_A  = 4;
    localparam int ERRF_OP_A   = 3;
    localparam int ERRF_DATA_B = 2;
    localparam int ERRF_CRC_B  = 1;
    localparam int ERRF_OP_B   = 0;

    // Field layout of a CTL packet payload
    localparam int CTL_ERR_BIT   = 7;  // 1 = error response
    localparam int CTL_FLAGS_LSB = 3;  // result: flags in [6:3], crc in [2:0]
    localparam int CTL_ERRF_LSB  = 1;  // error: err_flags in [6:1], parity in [0]

    // CRC3, polynomial x^3+x+1, init 0, message shifted in MSB first
    function automatic logic [2:0] crc3(input logic [36:0] d);
        logic [2:0] c;
        logic       fb;
        c = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = c[2] ^ d[i];
            c  = {c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mtm_alu_pkt_rx.sv
`default_nettype none
// ============================================================================
//  Module      : mtm_alu_pkt_rx
//  Description : Bit-level receiver for one 11-bit MTM ALU packet. Hunts for a
//                start bit on an idle-high line, shifts in type and data, and
//                flags the outcome on the cycle the stop bit is on the line.
//  Revision    : 1.0 - initial release
// ============================================================================
module mtm_alu_pkt_rx
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sout,
    output logic       pkt_valid,
    output logic       pkt_type,
    output logic [7:0] pkt_data,
    output logic       pkt_stop_err,
    output logic       line_idle
);

    localparam logic [1:0] c_st_hunt      = 2'd0;
    localparam logic [1:0] c_st_shift     = 2'd1;
    localparam logic [1:0] c_st_wait_high = 2'd2;

    localparam int                 c_cnt_w    = $clog2(PKT_BITS);
    // Index of the stop bit counted from the first bit after start
    localparam logic [c_cnt_w-1:0] c_stop_idx = c_cnt_w'(PKT_BITS - 2);

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [8:0]         r_shift;
    logic               w_stop_cycle;

    // The stop bit is judged combinationally so the top can register the
    // response on the very edge that samples it.
    assign w_stop_cycle = (r_state == c_st_shift) && (r_cnt == c_stop_idx);
    assign pkt_valid    = w_stop_cycle &&  sout;
    assign pkt_stop_err = w_stop_cycle && !sout;
    assign pkt_type     = r_shift[8];
    assign pkt_data     = r_shift[7:0];
    assign line_idle    = (r_state == c_st_hunt) && sout;

    // Start detection, bit shifting and stop-bit recovery
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_hunt;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                c_st_hunt: begin
                    r_cnt <= '0;
                    if (!sout) begin
                        r_state <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    if (r_cnt == c_stop_idx) begin
                        r_cnt   <= '0;
                        // A bad stop leaves the line low; wait for it to rise
                        r_state <= sout ? c_st_hunt : c_st_wait_high;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_shift <= {r_shift[7:0], sout};
                    end
                end
                c_st_wait_high: begin
                    if (sout) begin
                        r_state <= c_st_hunt;
                    end
                end
                default: begin
                    r_state <= c_st_hunt;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mtm_alu_resp_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : mtm_alu_resp_receiver
//  Description : Host-side MTM ALU response receiver. Assembles result
//                (4 DATA + CTL) and error (single CTL) responses, checks the
//                packet sequence and inter-packet timeout, and presents one
//                registered response per frame.
//                Optional macro MTM_ALU_RESP_CHECK_EN enables the CRC3/parity
//                check reported on chk_err; without it chk_err is tied 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mtm_alu_resp_receiver
    import mtm_alu_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sout,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_c,
    output logic [3:0]  rsp_flags,
    output logic [5:0]  rsp_err_flags,
    output logic        chk_err,
    output logic        frame_err
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_data1 = 3'd1;
    localparam logic [2:0] c_st_data2 = 3'd2;
    localparam logic [2:0] c_st_data3 = 3'd3;
    localparam logic [2:0] c_st_ctl   = 3'd4;

    localparam int               c_c_w    = 8 * DATA_BYTES;
    localparam int               c_to_w   = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [c_to_w-1:0] c_to_max = c_to_w'(IDLE_TIMEOUT);

    logic              w_pkt_valid;
    logic              w_pkt_type;
    logic [7:0]        w_pkt_data;
    logic              w_pkt_stop_err;
    logic              w_line_idle;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [c_to_w-1:0] r_idle_cnt;
    logic [c_c_w-1:0]  r_c_acc;

    logic              w_is_ctl;
    logic              w_ctl_is_err;
    logic              w_in_resp;
    logic              w_timeout;
    logic              w_take_result;
    logic              w_take_error;
    logic              w_frame_bad;
    logic [3:0]        w_flags;
    logic [5:0]        w_err_flags;

    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [31:0]       r_rsp_c;
    logic [3:0]        r_rsp_flags;
    logic [5:0]        r_rsp_err_flags;
    logic              r_frame_err;

    mtm_alu_pkt_rx u_pkt_rx (
        .clk          (clk),
        .rst          (rst),
        .sout         (sout),
        .pkt_valid    (w_pkt_valid),
        .pkt_type     (w_pkt_type),
        .pkt_data     (w_pkt_data),
        .pkt_stop_err (w_pkt_stop_err),
        .line_idle    (w_line_idle)
    );

    assign w_is_ctl     = (w_pkt_type == PKT_CTL);
    assign w_ctl_is_err = w_pkt_data[CTL_ERR_BIT];
    assign w_in_resp    = (r_state != c_st_idle);
    // Fires on the idle cycle that would exceed the allowed gap
    assign w_timeout    = w_in_resp && w_line_idle && (r_idle_cnt == c_to_max);

    // Unpack the CTL payload fields into the output bit order
    always_comb begin
        w_flags                  = '0;
        w_flags[FLAG_CARRY]      = w_pkt_data[CTL_FLAGS_LSB + FLAG_CARRY];
        w_flags[FLAG_OVERFLOW]   = w_pkt_data[CTL_FLAGS_LSB + FLAG_OVERFLOW];
        w_flags[FLAG_ZERO]       = w_pkt_data[CTL_FLAGS_LSB + FLAG_ZERO];
        w_flags[FLAG_NEGATIVE]   = w_pkt_data[CTL_FLAGS_LSB + FLAG_NEGATIVE];
        w_err_flags              = '0;
        w_err_flags[ERRF_DATA_A] = w_pkt_data[CTL_ERRF_LSB + ERRF_DATA_A];
        w_err_flags[ERRF_CRC_A]  = w_pkt_data[CTL_ERRF_LSB + ERRF_CRC_A];
        w_err_flags[ERRF_OP_A]   = w_pkt_data[CTL_ERRF_LSB + ERRF_OP_A];
        w_err_flags[ERRF_DATA_B] = w_pkt_data[CTL_ERRF_LSB + ERRF_DATA_B];
        w_err_flags[ERRF_CRC_B]  = w_pkt_data[CTL_ERRF_LSB + ERRF_CRC_B];
        w_err_flags[ERRF_OP_B]   = w_pkt_data[CTL_ERRF_LSB + ERRF_OP_B];
    end

    // Response sequencing: decide next state and what this packet completes
    always_comb begin
        w_next_state  = r_state;
        w_take_result = 1'b0;
        w_take_error  = 1'b0;
        w_frame_bad   = 1'b0;
        if (w_pkt_stop_err || w_timeout) begin
            w_frame_bad  = 1'b1;
            w_next_state = c_st_idle;
        end else if (w_pkt_valid) begin
            case (r_state)
                c_st_idle: begin
                    if (!w_is_ctl) begin
                        w_next_state = c_st_data1;
                    end else if (w_ctl_is_err) begin
                        w_take_error = 1'b1;
                    end else begin
                        w_frame_bad  = 1'b1;
                    end
                end
                c_st_data1, c_st_data2, c_st_data3: begin
                    if (w_is_ctl) begin
                        w_frame_bad  = 1'b1;
                        w_next_state = c_st_idle;
                    end else begin
                        w_next_state = r_state + 3'd1;
                    end
                end
                c_st_ctl: begin
                    w_next_state = c_st_idle;
                    if (w_is_ctl && !w_ctl_is_err) begin
                        w_take_result = 1'b1;
                    end else begin
                        w_frame_bad   = 1'b1;
                    end
                end
                default: begin
                    w_next_state = c_st_idle;
                end
            endcase
        end
    end

    // State register and byte assembly; DATA bytes arrive MSB first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_c_acc <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pkt_valid && !w_is_ctl) begin
                r_c_acc <= {r_c_acc[c_c_w-9:0], w_pkt_data};
            end
        end
    end

    // Idle-line counter, live only between packets of one response
    always_ff @(posedge clk) begin
        if (rst || !w_in_resp || !w_line_idle || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Registered response outputs; payload fields hold between responses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid     <= 1'b0;
            r_rsp_err       <= 1'b0;
            r_rsp_c         <= '0;
            r_rsp_flags     <= '0;
            r_rsp_err_flags <= '0;
            r_frame_err     <= 1'b0;
        end else begin
            r_rsp_valid <= w_take_result || w_take_error;
            r_frame_err <= w_frame_bad;
            if (w_take_result) begin
                r_rsp_err   <= 1'b0;
                r_rsp_c     <= r_c_acc;
                r_rsp_flags <= w_flags;
            end
            if (w_take_error) begin
                r_rsp_err       <= 1'b1;
                r_rsp_err_flags <= w_err_flags;
            end
        end
    end

`ifdef MTM_ALU_RESP_CHECK_EN
    logic w_crc_bad;
    logic w_par_bad;
    logic r_chk_err;

    assign w_crc_bad = (crc3({r_c_acc, 1'b0, w_flags}) != w_pkt_data[2:0]);
    assign w_par_bad = ((^{1'b1, w_err_flags}) != w_pkt_data[0]);

    // Check result travels with the response it belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_err <= 1'b0;
        end else if (w_take_result) begin
            r_chk_err <= w_crc_bad;
        end else if (w_take_error) begin
            r_chk_err <= w_par_bad;
        end
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

    assign rsp_valid     = r_rsp_valid;
    assign rsp_err       = r_rsp_err;
    assign rsp_c         = r_rsp_c;
    assign rsp_flags     = r_rsp_flags;
    assign rsp_err_flags = r_rsp_err_flags;
    assign frame_err     = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_resp_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mtm_alu_resp_receiver
//  Description : Directed self-checking bench for mtm_alu_resp_receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mtm_alu_resp_receiver;

`ifdef MTM_ALU_RESP_CHECK_EN
    localparam logic c_chk_en = 1'b1;
`else
    localparam logic c_chk_en = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        sout;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_c;
    logic [3:0]  rsp_flags;
    logic [5:0]  rsp_err_flags;
    logic        chk_err;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_ferr   = 0;
    int n_both   = 0;
    int v0;
    int f0;

    mtm_alu_resp_receiver #(.IDLE_TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .sout          (sout),
        .rsp_valid     (rsp_valid),
        .rsp_err       (rsp_err),
        .rsp_c         (rsp_c),
        .rsp_flags     (rsp_flags),
        .rsp_err_flags (rsp_err_flags),
        .chk_err       (chk_err),
        .frame_err     (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (rsp_valid) n_valid++;
        if (frame_err) n_ferr++;
        if (rsp_valid && frame_err) n_both++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC3 as polynomial long division of {msg, 000} by 1011
    function automatic logic [2:0] ref_crc(input logic [36:0] m);
        logic [39:0] r;
        r = {m, 3'b000};
        for (int i = 39; i >= 3; i--) begin
            if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        end
        return r[2:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sout = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_pkt(input logic typ, input logic [7:0] d, input logic stop);
        logic [10:0] bits;
        bits = {1'b0, typ, d, stop};
        for (int i = 10; i >= 0; i--) begin
            sout = bits[i];
            tick();
        end
    endtask

    task automatic send_result(input logic [31:0] c, input logic [3:0] f, input logic flip);
        logic [2:0] crc;
        crc = ref_crc({c, 1'b0, f});
        if (flip) crc[0] = ~crc[0];
        send_pkt(1'b0, c[31:24], 1'b1);
        send_pkt(1'b0, c[23:16], 1'b1);
        send_pkt(1'b0, c[15:8],  1'b1);
        send_pkt(1'b0, c[7:0],   1'b1);
        send_pkt(1'b1, {1'b0, f, crc}, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"},  32'(rsp_valid), 32'd0);
        check_eq({tag, "_err"},    32'(rsp_err), 32'd0);
        check_eq({tag, "_c"},      rsp_c, 32'd0);
        check_eq({tag, "_flags"},  32'(rsp_flags), 32'd0);
        check_eq({tag, "_eflags"}, 32'(rsp_err_flags), 32'd0);
        check_eq({tag, "_chk"},    32'(chk_err), 32'd0);
        check_eq({tag, "_ferr"},   32'(frame_err), 32'd0);
    endtask

    initial begin
        rst  = 1'b1;
        sout = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        idle(4);

        // 1: plain result, hand-computed CRC of C=1 flags=0 is 3'b010
        check_eq("crc_ref", 32'(ref_crc({32'h1, 1'b0, 4'h0})), 32'h2);
        v0 = n_valid; f0 = n_ferr;
        send_pkt(1'b0, 8'h00, 1'b1);
        send_pkt(1'b0, 8'h00, 1'b1);
        send_pkt(1'b0, 8'h00, 1'b1);
        send_pkt(1'b0, 8'h01, 1'b1);
        check_eq("t1_latency_ferr", 32'(frame_err), 32'd0);
        check_eq("t1_pulse_now", 32'(rsp_valid), 32'd0);
        send_pkt(1'b1, 8'b0_0000_010, 1'b1);
        check_eq("t1_pulse_next_cycle", 32'(rsp_valid), 32'd1);
        idle(3);
        check_eq("t1_valid_cnt", 32'(n_valid - v0), 32'd1);
        check_eq("t1_err", 32'(rsp_err), 32'd0);
        check_eq("t1_c", rsp_c, 32'h1);
        check_eq("t1_flags", 32'(rsp_flags), 32'h0);
        check_eq("t1_chk", 32'(chk_err), 32'd0);
        check_eq("t1_ferr_cnt", 32'(n_ferr - f0), 32'd0);

        // 2: corrupted CRC
        v0 = n_valid;
        send_result(32'h0000_0001, 4'b0000, 1'b1);
        idle(3);
        check_eq("t2_valid_cnt", 32'(n_valid - v0), 32'd1);
        check_eq("t2_chk", 32'(chk_err), 32'(c_chk_en));
        check_eq("t2_c", rsp_c, 32'h1);

        // 3: error response, err_flags=100100, par=1
        v0 = n_valid;
        send_pkt(1'b1, 8'b1_100100_1, 1'b1);
        idle(3);
        check_eq("t3_valid_cnt", 32'(n_valid - v0), 32'd1);
        check_eq("t3_err", 32'(rsp_err), 32'd1);
        check_eq("t3_eflags", 32'(rsp_err_flags), 32'h24);
        check_eq("t3_chk", 32'(chk_err), 32'd0);
        check_eq("t3_c_hold", rsp_c, 32'h1);
        check_eq("t3_flags_hold", 32'(rsp_flags), 32'h0);

        // 3b: error response with bad parity
        v0 = n_valid;
        send_pkt(1'b1, 8'b1_000011_0, 1'b1);
        idle(3);
        check_eq("t3b_valid_cnt", 32'(n_valid - v0), 32'd1);
        check_eq("t3b_eflags", 32'(rsp_err_flags), 32'h03);
        check_eq("t3b_chk", 32'(chk_err), 32'(c_chk_en));

        // 4: stop bit 0 in the second DATA packet, then a good result
        v0 = n_valid; f0 = n_ferr;
        send_pkt(1'b0, 8'hFF, 1'b1);
        send_pkt(1'b0, 8'hAA, 1'b0);
        idle(4);
        check_eq("t4_ferr_cnt", 32'(n_ferr - f0), 32'd1);
        check_eq("t4_no_valid", 32'(n_valid - v0), 32'd0);
        send_result(32'hFFFF_FFFF, 4'b0001, 1'b0);
        idle(3);
        check_eq("t4_valid_cnt", 32'(n_valid - v0), 32'd1);
        check_eq("t4_err", 32'(rsp_err), 32'd0);
        check_eq("t4_c", rsp_c, 32'hFFFF_FFFF);
        check_eq("t4_flags", 32'(rsp_flags), 32'h1);
        check_eq("t4_chk", 32'(chk_err), 32'd0);
        check_eq("t4_eflags_hold", 32'(rsp_err_flags), 32'h03);

        // 4b: CTL in place of a DATA packet, and a result CTL arriving first
        f0 = n_ferr; v0 = n_valid;
        send_pkt(1'b0, 8'h11, 1'b1);
        send_pkt(1'b1, 8'h00, 1'b1);
        idle(2);
        send_pkt(1'b1, 8'h05, 1'b1);
        idle(3);
        check_eq("t4b_ferr_cnt", 32'(n_ferr - f0), 32'd2);
        check_eq("t4b_no_valid", 32'(n_valid - v0), 32'd0);

        // 5a: gap of exactly IDLE_TIMEOUT after the third DATA packet
        v0 = n_valid; f0 = n_ferr;
        send_pkt(1'b0, 8'h12, 1'b1);
        send_pkt(1'b0, 8'h34, 1'b1);
        send_pkt(1'b0, 8'h56, 1'b1);
        idle(16);
        send_pkt(1'b0, 8'h78, 1'b1);
        send_pkt(1'b1, {1'b0, 4'b1010, ref_crc({32'h12345678, 1'b0, 4'b1010})}, 1'b1);
        idle(3);
        check_eq("t5a_valid_cnt", 32'(n_valid - v0), 32'd1);
        check_eq("t5a_ferr_cnt", 32'(n_ferr - f0), 32'd0);
        check_eq("t5a_c", rsp_c, 32'h1234_5678);
        check_eq("t5a_flags", 32'(rsp_flags), 32'hA);

        // 5b: gap of IDLE_TIMEOUT+1
        v0 = n_valid; f0 = n_ferr;
        send_pkt(1'b0, 8'hAB, 1'b1);
        send_pkt(1'b0, 8'hCD, 1'b1);
        send_pkt(1'b0, 8'hEF, 1'b1);
        idle(17);
        check_eq("t5b_ferr_at_17", 32'(frame_err), 32'd1);
        idle(5);
        check_eq("t5b_ferr_cnt", 32'(n_ferr - f0), 32'd1);
        check_eq("t5b_no_valid", 32'(n_valid - v0), 32'd0);

        // 6: two back-to-back results, then reset mid-packet of a third
        v0 = n_valid; f0 = n_ferr;
        send_result(32'hDEAD_BEEF, 4'b1100, 1'b0);
        check_eq("t6_first_c", 32'(rsp_valid), 32'd1);
        send_result(32'h8000_0000, 4'b1001, 1'b0);
        check_eq("t6_second_pulse", 32'(rsp_valid), 32'd1);
        check_eq("t6_second_c", rsp_c, 32'h8000_0000);
        sout = 1'b0; tick();
        sout = 1'b0; tick();
        sout = 1'b1; tick();
        sout = 1'b0; tick();
        check_eq("t6_valid_cnt", 32'(n_valid - v0), 32'd2);
        rst  = 1'b1;
        sout = 1'b1;
        tick();
        rst  = 1'b0;
        check_all_zero("t6_after_rst");
        v0 = n_valid; f0 = n_ferr;
        idle(25);
        check_eq("t6_no_valid", 32'(n_valid - v0), 32'd0);
        check_eq("t6_no_ferr", 32'(n_ferr - f0), 32'd0);
        check_eq("t6_c_still_0", rsp_c, 32'd0);

        check_eq("never_both", 32'(n_both), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
